axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 slave endpoint that terminates bursts arriving from an AXI master port (e.g. the master side of a clock-domain bridge) and services them from an internal word-addressed SRAM.
- Used as an on-chip memory target and as the simulation/FPGA stand-in for external memory.
- Handles one transaction at a time, either write or read. Beats are sustained at one per cycle.

Parameters:
- ADDR_WIDTH, 32, AXI byte-address width.
- DATA_WIDTH, 32, AXI data width; one beat is one SRAM word.
- SIZE_WORDS, 4096, SRAM depth in words; must be a power of two.

Ports:
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset.
- axi_bus  axi4_interface.slave  -  AXI bus. Members used:
  - m_awaddr, m_awlen, m_awvalid, s_awready
  - m_wdata, m_wlast, m_wvalid, s_wready
  - s_bvalid, m_bready
  - m_araddr, m_arlen, m_arvalid, s_arready
  - s_rdata, s_rvalid, m_rready

Behaviour:
- States: IDLE, WRITE_BURST, WRITE_RESP, READ_BURST.
- Reset (reset low, asserted asynchronously, released synchronously to clk):
  - state=IDLE; last_grant=READ.
  - s_awready, s_wready, s_bvalid, s_arready, s_rvalid all 0; s_rdata 0.
  - SRAM contents are not reset.
  - Reset mid-burst abandons the burst. No response is produced and beats already written remain written.
- Word index = byte_addr[log2(SIZE_WORDS)+1:2]. Low 2 bits are ignored. Higher bits alias.
- Within a burst the index increments by 1 per beat and wraps modulo SIZE_WORDS.
- IDLE:
  - s_awready=1 and s_arready=1, except when both valids are high.
  - If both m_awvalid and m_arvalid are high in the same cycle, only the channel not equal to last_grant gets ready=1.
  - AW handshake: latch index and beat_count=m_awlen, set last_grant=WRITE, go to WRITE_BURST.
  - AR handshake: issue SRAM read of the index, set beat_count=m_arlen, set last_grant=READ, go to READ_BURST.
- WRITE_BURST:
  - s_wready=1.
  - Each m_wvalid beat writes m_wdata to mem[index], then index++.
  - When the beat is taken with beat_count==0, go to WRITE_RESP; otherwise beat_count--.
  - Burst length comes from awlen only. m_wlast is ignored for control.
- WRITE_RESP:
  - s_bvalid=1, held until m_bready; then return to IDLE.
  - s_bvalid is first asserted the cycle after the last W beat.
- READ_BURST:
  - s_rvalid=1 the cycle after the AR handshake (latency 1).
  - s_rdata is a register loaded from the SRAM synchronous read port. It holds stable while s_rvalid && !m_rready.
  - On handshake with beat_count!=0: read mem[index+1], beat_count--. The next beat is presented the following cycle with no bubble.
  - On handshake with beat_count==0: s_rvalid=0 and go to IDLE.
- Write-then-read of the same address in back-to-back transactions returns the new data. The SRAM is written before the AR handshake can occur.
- Ready/valid outputs are registered or decoded from state only. Master valids never combinationally gate a same-channel ready, except the IDLE tie-break.

Optional Feature:
- Macro: AXI_SRAM_RESPONDER_WAIT_STATE_EN.
- Defined: adds parameter WAIT_CYCLES (default 4).
  - A down-counter delays the first s_rvalid of each read burst by WAIT_CYCLES extra cycles.
  - It also delays the first s_wready of each write burst by the same amount.
  - Models slow memory for bridge stress testing.
- Undefined: no counter. Latencies are exactly as in Behaviour.

Decomposition:
- Package axi_sram_responder_pkg holds:
  - the state enum typedef;
  - the grant enum (WRITE/READ);
  - localparam word-index-width function of SIZE_WORDS.
- One sub-module: sram_1r1w (DATA_WIDTH x SIZE_WORDS, synchronous read, one write port). The responder FSM, counters and arbitration stay in the top module.

Test Plan:
- Single write then read: AW addr 0x10 len 0, W 0xDEADBEEF; then AR 0x10 len 0.
  - s_bvalid one cycle after the W beat.
  - s_rvalid one cycle after the AR handshake with s_rdata=0xDEADBEEF.
- 8-beat write at 0x100 with data 1..8, then 8-beat read at 0x100 with m_rready=1 throughout.
  - rvalid high for 8 consecutive cycles, data 1..8, then IDLE.
- Read backpressure: 4-beat read with m_rready toggling 1,0,0,1,...
  - s_rdata stable while stalled; all 4 values delivered in order; no duplicates or drops.
- Simultaneous AW/AR in IDLE, twice in a row with both valids held.
  - First grant goes to write (last_grant=READ after reset); second goes to read.
- Wrap: SIZE_WORDS=16, 4-beat write at byte addr 0x38, data A,B,C,D.
  - mem[14]=A, mem[15]=B, mem[0]=C, mem[1]=D.
- Reset asserted mid 8-beat read after beat 3.
  - All outputs 0 immediately; after release, a new 1-beat read returns the correct data.

Source files
------------

// File: rtl/axi_sram_responder_pkg.sv
// axi_sram_responder_pkg: shared types and sizing helpers for the AXI SRAM responder.
`default_nettype none

package axi_sram_responder_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_BURST = 2'd1,
        ST_WRITE_RESP  = 2'd2,
        ST_READ_BURST  = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    function automatic int idx_width(input int size_words);
        return (size_words > 1) ? $clog2(size_words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_interface.sv
// axi4_interface: reduced AXI4 signal bundle (address, data, handshake) between master and slave.
`default_nettype none

interface axi4_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic                  m_awvalid;
    logic                  s_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  s_wready;
    logic                  s_bvalid;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic                  m_arvalid;
    logic                  s_arready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_rvalid;
    logic                  m_rready;

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid,
        input  m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
        output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );

    modport master (
        output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid,
        output m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
        input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_sram_responder_sram_1r1w.sv
// sram_1r1w: word SRAM with one write port and one synchronous read port.
// Only the read-data register is reset; array contents are left untouched.
`default_nettype none

module sram_1r1w
    import axi_sram_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WORDS = 4096
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               we_i,
    input  logic [idx_width(SIZE_WORDS)-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    input  logic                               re_i,
    input  logic [idx_width(SIZE_WORDS)-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]              rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [SIZE_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Holds its value when re_i is low, which gives the responder stall-stable read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave serving one burst at a time from an internal SRAM.
// Optional macro AXI_SRAM_RESPONDER_WAIT_STATE_EN adds WAIT_CYCLES of first-beat latency.
`default_nettype none

module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WORDS = 4096
`ifdef AXI_SRAM_RESPONDER_WAIT_STATE_EN
    ,
    parameter int WAIT_CYCLES = 4
`endif
) (
    input  logic          clk,
    input  logic          reset,
    axi4_interface.slave  axi_bus
);

    localparam int IW = idx_width(SIZE_WORDS);

    state_e                state_q, state_d;
    grant_e                grant_q, grant_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
    logic                  en_q;
    logic                  wait_done;

    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [IW-1:0]         aw_idx, ar_idx;
    logic                  both_valid;
    logic                  awready, arready, wready, bvalid, rvalid;
    logic                  sram_we, sram_re;
    logic [IW-1:0]         sram_raddr;
    logic                  unused_bits;

    assign awaddr     = axi_bus.m_awaddr;
    assign araddr     = axi_bus.m_araddr;
    assign aw_idx     = awaddr[IW+1:2];
    assign ar_idx     = araddr[IW+1:2];
    assign both_valid = axi_bus.m_awvalid && axi_bus.m_arvalid;
    // Upper address bits alias and wlast never steers control.
    assign unused_bits = ^{awaddr, araddr, axi_bus.m_wlast};

`ifdef AXI_SRAM_RESPONDER_WAIT_STATE_EN
    localparam int WW = $clog2(WAIT_CYCLES + 1) + 1;
    logic [WW-1:0] wait_q, wait_d;
    assign wait_done = (wait_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_READ;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sram_we    = 1'b0;
        sram_re    = 1'b0;
        sram_raddr = idx_q;
        awready    = 1'b0;
        arready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        rvalid     = 1'b0;
`ifdef AXI_SRAM_RESPONDER_WAIT_STATE_EN
        wait_d     = wait_done ? wait_q : (wait_q - 1'b1);
`endif

        case (state_q)
            ST_IDLE: begin
                // On a simultaneous request the channel not served last time wins.
                awready = en_q && (!both_valid || (grant_q == GRANT_READ));
                arready = en_q && (!both_valid || (grant_q == GRANT_WRITE));
                if (awready && axi_bus.m_awvalid) begin
                    idx_d   = aw_idx;
                    cnt_d   = axi_bus.m_awlen;
                    grant_d = GRANT_WRITE;
                    state_d = ST_WRITE_BURST;
`ifdef AXI_SRAM_RESPONDER_WAIT_STATE_EN
                    wait_d  = WW'(WAIT_CYCLES);
`endif
                end else if (arready && axi_bus.m_arvalid) begin
                    sram_re    = 1'b1;
                    sram_raddr = ar_idx;
                    idx_d      = ar_idx;
                    cnt_d      = axi_bus.m_arlen;
                    grant_d    = GRANT_READ;
                    state_d    = ST_READ_BURST;
`ifdef AXI_SRAM_RESPONDER_WAIT_STATE_EN
                    wait_d     = WW'(WAIT_CYCLES);
`endif
                end
            end
            ST_WRITE_BURST: begin
                wready = wait_done;
                if (wready && axi_bus.m_wvalid) begin
                    sram_we = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_WRITE_RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_WRITE_RESP: begin
                bvalid = 1'b1;
                if (axi_bus.m_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_BURST: begin
                rvalid = wait_done;
                if (rvalid && axi_bus.m_rready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Prefetch the next word so it appears on the following cycle.
                        sram_re    = 1'b1;
                        sram_raddr = idx_q + 1'b1;
                        idx_d      = idx_q + 1'b1;
                        cnt_d      = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE_WORDS (SIZE_WORDS)
    ) u_sram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (sram_we),
        .waddr_i (idx_q),
        .wdata_i (axi_bus.m_wdata),
        .re_i    (sram_re),
        .raddr_i (sram_raddr),
        .rdata_o (axi_bus.s_rdata)
    );

    assign axi_bus.s_awready = awready;
    assign axi_bus.s_arready = arready;
    assign axi_bus.s_wready  = wready;
    assign axi_bus.s_bvalid  = bvalid;
    assign axi_bus.s_rvalid  = rvalid;

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed checks of the AXI SRAM responder with a 16-word memory.
`default_nettype none

module tb_axi_sram_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    axi4_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_sram_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SIZE_WORDS (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .axi_bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] seq [8];
    logic [31:0] wrp [8];
    logic [31:0] one [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_req(input logic [31:0] a, input int len);
        int n = 0;
        bus.m_awaddr  = a;
        bus.m_awlen   = 8'(len);
        bus.m_awvalid = 1'b1;
        #1;
        while (!bus.s_awready && n < 16) begin
            step();
            n++;
        end
        chk("aw_handshake", 32'(n < 16), 32'd1);
        step();
        bus.m_awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [31:0] a, input int len);
        int n = 0;
        bus.m_araddr  = a;
        bus.m_arlen   = 8'(len);
        bus.m_arvalid = 1'b1;
        #1;
        while (!bus.s_arready && n < 16) begin
            step();
            n++;
        end
        chk("ar_handshake", 32'(n < 16), 32'd1);
        step();
        bus.m_arvalid = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] a, input int len, input logic [31:0] d [8]);
        aw_req(a, len);
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            bus.m_wdata  = d[i];
            bus.m_wvalid = 1'b1;
            bus.m_wlast  = (i == len);
            #1;
            while (!bus.s_wready && n < 16) begin
                step();
                n++;
            end
            chk("w_ready", 32'(bus.s_wready), 32'd1);
            step();
        end
        bus.m_wvalid = 1'b0;
        bus.m_wlast  = 1'b0;
        #1;
        chk("b_latency", 32'(bus.s_bvalid), 32'd1);
        bus.m_bready = 1'b1;
        step();
        bus.m_bready = 1'b0;
        #1;
        chk("b_done", 32'(bus.s_bvalid), 32'd0);
    endtask

    // mode 0: rready always high; mode 1: rready pattern 1,0,0 repeating.
    task automatic read_burst(input logic [31:0] a, input int len, input logic [31:0] e [8],
                              input int mode, output int cycles);
        int          k       = 0;
        int          cyc     = 0;
        logic        stalled = 1'b0;
        logic [31:0] held    = '0;
        ar_req(a, len);
        #1;
        chk("r_latency", 32'(bus.s_rvalid), 32'd1);
        while (k <= len && cyc < 64) begin
            bus.m_rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (bus.s_rvalid) begin
                if (stalled) chk("r_hold", bus.s_rdata, held);
                if (bus.m_rready) begin
                    chk("r_data", bus.s_rdata, e[k]);
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.s_rdata;
                end
            end
            step();
            cyc++;
        end
        bus.m_rready = 1'b0;
        #1;
        chk("r_end_rvalid", 32'(bus.s_rvalid), 32'd0);
        chk("r_beats", 32'(k), 32'(len + 1));
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        wrp = '{32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D, 0, 0, 0, 0};
        one = '{default: '0};
        bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awvalid = 1'b0;
        bus.m_wdata  = '0; bus.m_wlast = 1'b0; bus.m_wvalid = 1'b0;
        bus.m_bready = 1'b0;
        bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b0;

        #1 reset = 1'b0;
        #1;
        chk("rst_awready", 32'(bus.s_awready), 32'd0);
        chk("rst_arready", 32'(bus.s_arready), 32'd0);
        chk("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        chk("rst_rdata",   bus.s_rdata,        32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk("idle_awready", 32'(bus.s_awready), 32'd1);
        chk("idle_arready", 32'(bus.s_arready), 32'd1);

        // Simultaneous AW/AR held across two arbitration rounds.
        bus.m_awaddr = 32'h20; bus.m_awlen = 8'd0; bus.m_awvalid = 1'b1;
        bus.m_araddr = 32'h20; bus.m_arlen = 8'd0; bus.m_arvalid = 1'b1;
        #1;
        chk("tie1_awready", 32'(bus.s_awready), 32'd1);
        chk("tie1_arready", 32'(bus.s_arready), 32'd0);
        step();
        bus.m_wdata = 32'h1111_1111; bus.m_wvalid = 1'b1; bus.m_wlast = 1'b1;
        #1;
        chk("tie_wready", 32'(bus.s_wready), 32'd1);
        step();
        bus.m_wvalid = 1'b0; bus.m_wlast = 1'b0;
        #1;
        chk("tie_bvalid", 32'(bus.s_bvalid), 32'd1);
        bus.m_bready = 1'b1;
        step();
        bus.m_bready = 1'b0;
        #1;
        chk("tie2_awready", 32'(bus.s_awready), 32'd0);
        chk("tie2_arready", 32'(bus.s_arready), 32'd1);
        step();
        bus.m_awvalid = 1'b0; bus.m_arvalid = 1'b0;
        #1;
        chk("tie_rvalid", 32'(bus.s_rvalid), 32'd1);
        chk("tie_rdata",  bus.s_rdata, 32'h1111_1111);
        bus.m_rready = 1'b1;
        step();
        bus.m_rready = 1'b0;
        #1;
        chk("tie_rdone", 32'(bus.s_rvalid), 32'd0);

        // Single write then read back.
        one[0] = 32'hDEAD_BEEF;
        write_burst(32'h10, 0, one);
        read_burst(32'h10, 0, one, 0, cyc);

        // 8-beat write/read, no backpressure: eight consecutive valid cycles.
        write_burst(32'h100, 7, seq);
        read_burst(32'h100, 7, seq, 0, cyc);
        chk("burst8_cycles", 32'(cyc), 32'd8);
        chk("burst8_idle", 32'(bus.s_awready), 32'd1);

        // 4-beat read with rready 1,0,0,1,...
        read_burst(32'h100, 3, seq, 1, cyc);

        // Wrap at the top of a 16-word memory: 0x38 is word 14.
        write_burst(32'h38, 3, wrp);
        read_burst(32'h38, 3, wrp, 0, cyc);
        one[0] = 32'hCCCC_000C;
        read_burst(32'h00, 0, one, 0, cyc);
        one[0] = 32'hDDDD_000D;
        read_burst(32'h44, 0, one, 0, cyc);
        one[0] = 32'hBBBB_000B;
        read_burst(32'h3C, 0, one, 0, cyc);

        // Reset during an 8-beat read after three beats.
        ar_req(32'h100, 7);
        bus.m_rready = 1'b1;
        repeat (3) step();
        bus.m_rready = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        chk("mid_rst_rdata",   bus.s_rdata,        32'd0);
        chk("mid_rst_awready", 32'(bus.s_awready), 32'd0);
        chk("mid_rst_arready", 32'(bus.s_arready), 32'd0);
        chk("mid_rst_wready",  32'(bus.s_wready),  32'd0);
        chk("mid_rst_bvalid",  32'(bus.s_bvalid),  32'd0);
        step();
        reset = 1'b1;
        step();
        step();
        one[0] = 32'd3;
        read_burst(32'h108, 0, one, 0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
